// File: rtl/fsm_pkg.sv
// fsm_pkg: shared state encodings and instruction field constants for the ALU control FSM
package fsm_pkg;
  typedef enum logic [3:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MD_ISSUE,
    S_MD_WAIT,
    S_WRITEBACK,
    S_DONE,
    S_TRAP
  } state_e;
  localparam logic [1:0] SEL_RD_ALU = 2'b10;
  localparam logic [1:0] SEL_RD_MD  = 2'b11;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_IMM_W   = 7'b0011011;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRX     = 3'b101;
endpackage

// File: rtl/fsm_timeout_counter.sv
// fsm_timeout_counter: clearable wait counter flagging the last cycle before LIMIT is reached
module fsm_timeout_counter #(
  parameter int LIMIT = 80,
  parameter int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign tc = cnt_q == W'(LIMIT - 1);
endmodule

// File: rtl/fsm_alu_ext.sv
// fsm_alu_ext: Moore control FSM for integer ALU, W-form and mul/div instructions with timeout trap
module fsm_alu_ext
  import fsm_pkg::*;
#(
  parameter int XLEN = 64,
  parameter bit MULDIV_EN = 1'b1,
  parameter int MD_TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] insn,
  input  logic [31:0] code,
  input  logic        start,
  input  logic        md_ready,
  output logic        load_rs1,
  output logic        load_rs2,
  output logic        load_imm,
  output logic        load_alu,
  output logic        sel_alu_a,
  output logic        sel_alu_b,
  output logic        sub_sra,
  output logic        word_op,
  output logic        md_start,
  output logic [2:0]  md_op,
  output logic [1:0]  sel_rd,
  output logic        load_regfile,
  output logic        load_pc,
  output logic        done,
  output logic        error
);
  localparam int CW = $clog2(MD_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [31:0] insn_q, insn_d;
  logic r_type_q, r_type_d;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic md_path, md_go, illegal, md_clr, md_en, md_tc, unused_bits;
  assign opc = insn_q[6:0];
  assign f3 = insn_q[14:12];
  assign f7 = insn_q[31:25];
  assign md_path = r_type_q && f7 == F7_MULDIV;
  assign md_go = md_path && MULDIV_EN;
  assign illegal = (insn_q[3] && XLEN != 64)
                || (opc == OP_IMM_W && (f3 == F3_SLL || f3 == F3_SRX) && insn_q[25])
                || (md_path && !MULDIV_EN);
  assign md_clr = state_q == S_MD_ISSUE;
  assign md_en = state_q == S_MD_WAIT && !md_ready;
  assign unused_bits = ^{code[31:13], code[11:0], insn_q[24:15], insn_q[11:7]};
  fsm_timeout_counter #(.LIMIT(MD_TIMEOUT), .W(CW)) u_tmo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (md_clr),
    .en   (md_en),
    .tc   (md_tc)
  );
  always_comb begin
    state_d = state_q;
    insn_d = insn_q;
    r_type_d = r_type_q;
    load_rs1 = 1'b0;
    load_rs2 = 1'b0;
    load_imm = 1'b0;
    load_alu = 1'b0;
    sel_alu_a = 1'b0;
    sel_alu_b = 1'b0;
    sub_sra = 1'b0;
    md_start = 1'b0;
    load_regfile = 1'b0;
    load_pc = 1'b0;
    done = 1'b0;
    error = 1'b0;
    sel_rd = SEL_RD_ALU;
    word_op = insn_q[3] && !(state_q inside {S_IDLE, S_DONE, S_TRAP});
    md_op = (state_q == S_MD_ISSUE || state_q == S_MD_WAIT) ? f3 : 3'b000;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DECODE;
          insn_d = insn;
          r_type_d = code[12];
        end
      end
      S_DECODE: begin
        load_rs1 = 1'b1;
        load_rs2 = 1'b1;
        load_imm = 1'b1;
        state_d = illegal ? S_TRAP : md_go ? S_MD_ISSUE : r_type_q ? S_EXEC_R : S_EXEC_I;
      end
      S_EXEC_R: begin
        load_alu = 1'b1;
        sub_sra = insn_q[30];
        state_d = S_WRITEBACK;
      end
      S_EXEC_I: begin
        load_alu = 1'b1;
        sel_alu_b = 1'b1;
        sel_alu_a = opc == OP_AUIPC;
        sub_sra = f3 == F3_SRX && insn_q[30];
        state_d = S_WRITEBACK;
      end
      S_MD_ISSUE: begin
        md_start = 1'b1;
        state_d = S_MD_WAIT;
      end
      S_MD_WAIT: state_d = md_ready ? S_WRITEBACK : md_tc ? S_TRAP : S_MD_WAIT;
      S_WRITEBACK: begin
        load_regfile = 1'b1;
        load_pc = 1'b1;
        sel_rd = md_go ? SEL_RD_MD : SEL_RD_ALU;
        state_d = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        state_d = S_IDLE;
      end
      S_TRAP: begin
        done = 1'b1;
        error = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      insn_q <= '0;
      r_type_q <= 1'b0;
    end else begin
      state_q <= state_d;
      insn_q <= insn_d;
      r_type_q <= r_type_d;
    end
  end
endmodule
